// File: rtl/adc_capture_pkg.sv
// Shared types, widths and the ADC sample conversion for the chirp capture stage.
package adc_capture_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADC_W    = 13;
  localparam int FIFO_W   = SAMPLE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // Offset-binary 12-bit code to signed 16-bit: flipping the MSB gives two's
  // complement (0x800 -> 0), which is then sign-extended.
  function automatic logic [SAMPLE_W-1:0] adc_to_s16(input logic [ADC_W-2:0] code);
    logic msb_s;
    msb_s = ~code[ADC_W-2];
    return {{(SAMPLE_W-ADC_W+2){msb_s}}, code[ADC_W-3:0]};
  endfunction

endpackage

// File: rtl/adc_chirp_capture_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// A write into a full FIFO is accepted only when a read happens on the same cycle.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty_o = (count_r == {(AW+1){1'b0}});
  assign full_o  = (count_r == FULL_CNT);
  assign count_o = count_r;

  // Qualify requests: empty reads are no-ops, full writes need a same-cycle read.
  always_comb begin
    do_rd_s = 1'b0;
    do_wr_s = 1'b0;
    if (flush_i) begin
      do_rd_s = 1'b0;
      do_wr_s = 1'b0;
    end else begin
      do_rd_s = rd_en_i && !empty_o;
      do_wr_s = wr_en_i && (!full_o || do_rd_s);
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of queue is presented directly; zero while empty.
  always_comb begin
    if (empty_o) begin
      rd_data_o = {WIDTH{1'b0}};
    end else begin
      rd_data_o = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/adc_chirp_capture.sv
// Chirp-synchronous capture: after a trigger, skips a settling interval of
// valid samples, then converts and buffers a fixed number of samples with an
// end-of-chirp marker on the last one.
module adc_chirp_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       skip_i,
  input  logic [CNT_W-1:0]       samples_i,
  input  logic [ADC_W-1:0]       ad_data_i,
  input  logic                   ad_data_valid_i,
  output logic [SAMPLE_W-1:0]    m_data_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   or_flag_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  cap_state_e       state_r;
  cap_state_e       state_s;
  logic [CNT_W-1:0] skip_cnt_r;
  logic [CNT_W-1:0] skip_cnt_s;
  logic [CNT_W-1:0] samp_cnt_r;
  logic [CNT_W-1:0] samp_cnt_s;
  logic             cap_strobe_s;
  logic             last_s;
  logic             rd_s;
  logic             wr_s;
  logic             drop_s;
  logic             overflow_r;
  logic             or_flag_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [FIFO_W-1:0] fifo_rd_data_s;
  logic [FIFO_W-1:0] fifo_wr_data_s;

  // Next-state and counter logic; clear returns to IDLE ahead of everything.
  always_comb begin
    state_s      = state_r;
    skip_cnt_s   = skip_cnt_r;
    samp_cnt_s   = samp_cnt_r;
    cap_strobe_s = 1'b0;
    last_s       = 1'b0;
    if (clear_i) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && (samples_i != CNT_ZERO)) begin
            skip_cnt_s = skip_i;
            samp_cnt_s = samples_i;
            if (skip_i != CNT_ZERO) begin
              state_s = ST_SKIP;
            end else begin
              state_s = ST_CAPTURE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (ad_data_valid_i) begin
            skip_cnt_s = skip_cnt_r - CNT_ONE;
            if (skip_cnt_r == CNT_ONE) begin
              state_s = ST_CAPTURE;
            end else begin
              state_s = ST_SKIP;
            end
          end else begin
            state_s = ST_SKIP;
          end
        end
        ST_CAPTURE: begin
          if (ad_data_valid_i) begin
            cap_strobe_s = 1'b1;
            samp_cnt_s   = samp_cnt_r - CNT_ONE;
            if (samp_cnt_r == CNT_ONE) begin
              last_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_CAPTURE;
            end
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and chirp counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= CNT_ZERO;
      samp_cnt_r <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      skip_cnt_r <= skip_cnt_s;
      samp_cnt_r <= samp_cnt_s;
    end
  end

  // Write/read/drop decisions; a full FIFO still accepts when it is read this cycle.
  always_comb begin
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    drop_s = 1'b0;
    if (clear_i) begin
      rd_s   = 1'b0;
      wr_s   = 1'b0;
      drop_s = 1'b0;
    end else begin
      rd_s   = !fifo_empty_s && m_ready_i;
      wr_s   = cap_strobe_s && (!fifo_full_s || rd_s);
      drop_s = cap_strobe_s && !wr_s;
    end
  end

  assign fifo_wr_data_s = {last_s, adc_to_s16(ad_data_i[ADC_W-2:0])};

  // Sticky overflow and out-of-range flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      or_flag_r  <= 1'b0;
    end else if (clear_i) begin
      overflow_r <= 1'b0;
      or_flag_r  <= 1'b0;
    end else begin
      overflow_r <= overflow_r | drop_s;
      or_flag_r  <= or_flag_r | (cap_strobe_s & ad_data_i[ADC_W-1]);
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (clear_i),
    .wr_en_i   (wr_s),
    .wr_data_i (fifo_wr_data_s),
    .rd_en_i   (rd_s),
    .rd_data_o (fifo_rd_data_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fill_o)
  );

  assign m_data_o   = fifo_rd_data_s[SAMPLE_W-1:0];
  assign m_last_o   = fifo_rd_data_s[SAMPLE_W];
  assign m_valid_o  = !fifo_empty_s;
  assign busy_o     = (state_r != ST_IDLE);
  assign overflow_o = overflow_r;
  assign or_flag_o  = or_flag_r;

endmodule

// File: tb/tb_adc_chirp_capture.sv
// Bench for adc_chirp_capture: a queue-based reference model of the chirp
// capture plus directed scenarios and randomized traffic.
module tb_adc_chirp_capture;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] skip = '0;
  logic [CNT_W-1:0] samples = '0;
  logic [12:0]      ad_data = '0;
  logic             valid = 1'b0;
  logic             ready = 1'b0;
  logic [15:0]      m_data;
  logic             m_last;
  logic             m_valid;
  logic             busy;
  logic             overflow;
  logic             or_flag;
  logic [2:0]       fill;

  adc_chirp_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .skip_i          (skip),
    .samples_i       (samples),
    .ad_data_i       (ad_data),
    .ad_data_valid_i (valid),
    .m_data_o        (m_data),
    .m_last_o        (m_last),
    .m_valid_o       (m_valid),
    .m_ready_i       (ready),
    .busy_o          (busy),
    .overflow_o      (overflow),
    .or_flag_o       (or_flag),
    .fill_o          (fill)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model: expected FIFO contents as {last, data}, plus chirp progress.
  logic [16:0] q[$];
  logic [16:0] got[$];
  bit m_idle = 1'b1;
  int m_skip = 0;
  int m_left = 0;
  bit m_ovf  = 1'b0;
  bit m_orf  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_idle = 1'b1;
    m_skip = 0;
    m_left = 0;
    m_ovf  = 1'b0;
    m_orf  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, evaluated from the current inputs.
  task automatic model_step();
    bit rd;
    bit was_full;
    if (!rst_n || clear) begin
      model_reset();
      return;
    end
    rd = (q.size() != 0) && ready;
    was_full = (q.size() == DEPTH);
    if (rd) void'(q.pop_front());
    if (m_idle) begin
      if (start && samples != 0) begin
        m_idle = 1'b0;
        m_skip = int'(skip);
        m_left = int'(samples);
      end
    end else if (m_skip > 0) begin
      if (valid) m_skip--;
    end else if (valid) begin
      if (!was_full || rd) q.push_back({m_left == 1, 16'(int'(ad_data[11:0]) - 2048)});
      else m_ovf = 1'b1;
      if (ad_data[12]) m_orf = 1'b1;
      m_left--;
      if (m_left == 0) m_idle = 1'b1;
    end
  endtask

  // Compare DUT against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && ready) got.push_back({m_last, m_data});
    if (chk_en) begin
      chk("m_valid", int'(m_valid), int'(q.size() != 0));
      chk("fill", int'(fill), q.size());
      chk("busy", int'(busy), int'(!m_idle));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("or_flag", int'(or_flag), int'(m_orf));
      if (q.size() != 0) begin
        chk("m_data", int'(m_data), int'(q[0][15:0]));
        chk("m_last", int'(m_last), int'(q[0][16]));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    start = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
  endtask

  task automatic feed(input logic [12:0] d);
    ad_data = d;
    valid = 1'b1;
    cycle();
  endtask

  task automatic launch(input int sk, input int n);
    skip = CNT_W'(sk);
    samples = CNT_W'(n);
    start = 1'b1;
    cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      cycle();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  int lasts;
  logic [15:0] expd[4];
  logic [12:0] d;

  initial begin
    // Power-on reset and reset values.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_flags", int'({overflow, or_flag}), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Basic capture: skip 2, capture 4.
    ready = 1'b1;
    got.delete();
    launch(2, 4);
    chk("busy_after_start", int'(busy), 1);
    feed(13'h0800); feed(13'h0801); feed(13'h0FFF);
    feed(13'h0000); feed(13'h07FF); feed(13'h0100);
    repeat (3) cycle();
    chk("basic_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("basic_s0", int'($signed(got[0][15:0])), 2047);
      chk("basic_s1", int'($signed(got[1][15:0])), -2048);
      chk("basic_s2", int'($signed(got[2][15:0])), -1);
      chk("basic_s3", int'($signed(got[3][15:0])), -1792);
      chk("basic_lasts", int'({got[0][16], got[1][16], got[2][16], got[3][16]}), 1);
    end
    chk("basic_busy_end", int'(busy), 0);

    // Zero samples: nothing starts.
    launch(0, 0);
    feed(13'h0123);
    chk("zero_busy", int'(busy), 0);
    chk("zero_fill", int'(fill), 0);

    // Overflow with consumer stalled.
    do_clear();
    ready = 1'b0;
    launch(0, 6);
    for (int i = 0; i < 6; i++) begin
      d = 13'($urandom_range(0, 4095));
      if (i < 4) expd[i] = 16'(int'(d) - 2048);
      feed(d);
    end
    chk("ovf_fill", int'(fill), 4);
    chk("ovf_flag", int'(overflow), 1);
    got.delete();
    ready = 1'b1;
    repeat (6) cycle();
    chk("ovf_drain_count", got.size(), 4);
    lasts = 0;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      chk("ovf_drain_data", int'(got[i][15:0]), int'(expd[i]));
      lasts += int'(got[i][16]);
    end
    chk("ovf_no_last", lasts, 0);

    // Full FIFO with simultaneous read and write.
    do_clear();
    ready = 1'b0;
    launch(0, 5);
    for (int i = 0; i < 4; i++) feed(13'($urandom_range(0, 4095)));
    chk("full_fill", int'(fill), 4);
    ready = 1'b1;
    feed(13'h0ABC);
    chk("full_rw_fill", int'(fill), 4);
    chk("full_rw_ovf", int'(overflow), 0);
    repeat (6) cycle();

    // Out-of-range sample and ignored retrigger.
    do_clear();
    got.delete();
    launch(1, 3);
    feed(13'h0123);
    feed(13'h1800);
    skip = 16'd0; samples = 16'd7; start = 1'b1;
    feed(13'h0005);
    feed(13'h0006);
    chk("or_busy_end", int'(busy), 0);
    repeat (4) cycle();
    chk("or_flag_set", int'(or_flag), 1);
    chk("or_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("or_s0_zero", int'(got[0][15:0]), 0);
      chk("or_last", int'({got[0][16], got[1][16], got[2][16]}), 1);
    end

    // Clear mid-capture with fill 3.
    ready = 1'b0;
    launch(0, 10);
    for (int i = 0; i < 3; i++) feed(13'($urandom_range(0, 8191)));
    chk("clr_pre_fill", int'(fill), 3);
    do_clear();
    chk("clr_fill", int'(fill), 0);
    chk("clr_flags", int'({overflow, or_flag}), 0);
    chk("clr_busy", int'(busy), 0);

    // Asynchronous reset in SKIP.
    launch(5, 3);
    feed(13'h0111);
    feed(13'h0222);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(m_valid), 0);
    chk("arst_data", int'(m_data), 0);
    chk("arst_last", int'(m_last), 0);
    chk("arst_fill", int'(fill), 0);
    cycle();
    rst_n = 1'b1;
    repeat (3) feed(13'h0333);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        skip = CNT_W'($urandom_range(0, 3));
        samples = CNT_W'($urandom_range(0, 8));
      end
      clear = ($urandom_range(0, 149) == 0);
      ad_data = 13'($urandom_range(0, 8191));
      valid = ($urandom_range(0, 1) == 1);
      cycle();
    end
    ready = 1'b1;
    wait_idle();
    repeat (6) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adc_chirp_capture.md
# adc_chirp_capture

Chirp-synchronous sample capture stage directly downstream of the AD9226 ADC interface. It consumes the 13-bit sample/valid stream that the interface produces and, after a per-chirp trigger, discards a programmable settling interval. It then captures a programmable number of samples, converts them to signed 16-bit, and buffers them in a FIFO. The FIFO drains through a valid/ready stream with an end-of-chirp marker toward the range-FFT stage.

## Interface
- `DEPTH`, 1024: FIFO entries; power of two, ≥ 4.
- `CNT_W`, 16: width of the skip and sample-count configuration inputs.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear_i` in 1: synchronous flush.
  - Empties the FIFO, clears the sticky flags and returns the FSM to IDLE.
- `start_i` in 1: chirp trigger pulse. Sampled only in IDLE.
- `skip_i` in CNT_W: number of valid samples to discard after the trigger. Latched at start.
- `samples_i` in CNT_W: number of samples to capture per chirp. Latched at start.
- `ad_data_i` in 13: bit 12 is the ADC out-of-range flag; bits 11:0 are offset-binary data.
- `ad_data_valid_i` in 1: one-cycle strobe qualifying `ad_data_i`.
- `m_data_o` out 16: signed sample.
- `m_last_o` out 1: asserted with the final sample of a chirp.
- `m_valid_o` out 1: FIFO non-empty.
- `m_ready_i` in 1: consumer ready.
- `busy_o` out 1: FSM not in IDLE.
- `overflow_o` out 1: sticky; at least one sample was dropped because the FIFO was full.
- `or_flag_o` out 1: sticky; at least one captured sample had bit 12 set.
- `fill_o` out log2(DEPTH)+1: current FIFO occupancy.

## Operation
- FSM states: IDLE, SKIP, CAPTURE.
- IDLE, with `start_i` high and `samples_i` ≠ 0:
  - Latch `skip_i` and `samples_i`.
  - Go to SKIP if `skip_i` ≠ 0, otherwise go to CAPTURE.
- IDLE, with `start_i` high and `samples_i` = 0: stay in IDLE; nothing happens.
- `start_i` in SKIP or CAPTURE: ignored; no retrigger.
- SKIP:
  - Each `ad_data_valid_i` decrements the skip counter.
  - The valid that takes it to zero is discarded, and the FSM moves to CAPTURE.
- CAPTURE:
  - Each `ad_data_valid_i` decrements the sample counter and produces one sample.
  - The sample with the counter at 1 carries last=1, and the FSM returns to IDLE on that cycle.
- Conversion: data = sign-extend({~ad_data_i[11], ad_data_i[10:0]}) to 16 bits.
  - Range is -2048..+2047; 0x800 maps to 0.
  - Bit 12 does not alter the data; it only sets `or_flag_o`.
- Write condition: CAPTURE, valid, and (not full, or a read occurs on the same cycle).
- Drop: when the write condition fails, the sample is dropped and `overflow_o` is set.
  - The sample counter still advances, so the chirp timeline is preserved.
  - If the dropped sample is the last one, no `m_last_o` is emitted for that chirp.
- `clear_i` has priority over `start_i`, capture and read.
  - On the clear cycle no write or read takes effect.
- Counter widths are CNT_W; a value of 2^CNT_W−1 is legal.

## Timing
- Reset values:
  - `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `busy_o`=0, `overflow_o`=0, `or_flag_o`=0, `fill_o`=0.
  - FSM is in IDLE.
- `busy_o` rises on the cycle after an accepted `start_i`.
- `busy_o` falls on the cycle after the last-sample strobe.
- FIFO is first-word-fall-through:
  - A sample written at edge T appears on `m_data_o`/`m_valid_o` after edge T (visible in cycle T+1).
  - Write-to-output latency is 1 cycle when the FIFO was empty.
- Handshake:
  - A transfer occurs when `m_valid_o` && `m_ready_i`.
  - `m_data_o`/`m_last_o` remain stable while `m_valid_o`=1 and `m_ready_i`=0.
- Occupancy:
  - Simultaneous read and write leaves `fill_o` unchanged, including at full and at fill=1.
  - A read when empty is a no-op.
- Pointers wrap modulo DEPTH.
- A back-to-back valid every cycle is supported in both SKIP and CAPTURE.
- An asynchronous reset mid-chirp discards FIFO contents and all counters; there is no partial frame afterwards.

## Structure
- Package `adc_capture_pkg` contains:
  - The FSM state enum.
  - The `adc_to_s16` conversion function.
  - The sample width constant (16) and the ADC width constant (13).
- Sub-module `sync_fifo`: parameterised width (17, for data plus last) and DEPTH, with FWFT output, full/empty, count, and a synchronous flush.
- The top level holds the FSM, the counters, the conversion and the sticky flags.

## Test plan
- Basic capture:
  - Stimulus: skip=2, samples=4, valids carrying 0x800, 0x801, 0xFFF, 0x000, 0x7FF, 0x100, with `m_ready_i`=1.
  - Response: outputs 2047, −2048, −1, −1792, with last only on −1792.
- Zero samples: `samples_i`=0 with `start_i` → `busy_o` stays 0 and nothing is written.
- Overflow:
  - Stimulus: DEPTH=4, `m_ready_i`=0, samples=6.
  - Response: `fill_o`=4, `overflow_o`=1, and the first 4 samples drain intact with no `m_last_o`.
- Full with simultaneous read/write:
  - Stimulus: FIFO full, `m_ready_i`=1 on the same cycle as a valid.
  - Response: the write is accepted, `fill_o` stays 4 and `overflow_o` stays 0.
- Out-of-range and retrigger:
  - Stimulus: `ad_data_i`=0x1800, then `start_i` pulsed mid-capture.
  - Response: sample 0 is captured, `or_flag_o`=1, and the chirp length is unchanged.
- Clear and reset:
  - Stimulus: `clear_i` mid-CAPTURE with fill=3, then `rst_n` low mid-SKIP.
  - Response: fill=0, flags=0, IDLE, and all outputs at their reset values.
